// File: rtl/dac_write_scheduler.sv
// Stereo PWM DAC write scheduler: arbitrates DSP/CPU sample writes into a
// shared FIFO and drains it at a programmable rate onto the DAC strobes.
module dac_write_scheduler #(
  parameter int DEPTH = 8,
  parameter int RATEW = 10
) (
  input  logic                   MasterClock,
  input  logic                   RESETL,
  input  logic                   ENABLE,
  input  logic [RATEW-1:0]       RATE,
  input  logic                   DSPREQ,
  input  logic                   DSPCH,
  input  logic [15:0]            DSPD,
  output logic                   DSPACK,
  input  logic                   CPUREQ,
  input  logic                   CPUCH,
  input  logic [15:0]            CPUD,
  output logic                   CPUACK,
  input  logic                   CLRSTAT,
  output logic                   DACWRLL,
  output logic                   DACWRRL,
  output logic [15:0]            DACD,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   UNDERRUN
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic        ch;
    logic [15:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_n;
  logic             full_q;
  logic             empty_q;

  logic             armed_q;
  logic [RATEW-1:0] div_cnt;
  logic             tick;

  logic             dsp_grant;
  logic             cpu_grant;
  logic             push;
  logic             pop;
  entry_t           push_entry;
  entry_t           head;

  logic             wrl_q;
  logic             wrr_q;
  logic [15:0]      dacd_q;
  logic             underrun_q;

  // Fixed-priority grant; FULL is the registered flag, so a same-cycle pop
  // never opens a slot for a push.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    dsp_grant  = 1'b0;
    cpu_grant  = 1'b0;
    push_entry = '0;
    if (armed_q && !full_q) begin
      if (DSPREQ) begin
        dsp_grant  = 1'b1;
        push_entry = '{ch: DSPCH, data: DSPD};
      end else if (CPUREQ) begin
        cpu_grant  = 1'b1;
        push_entry = '{ch: CPUCH, data: CPUD};
      end
    end
  end

  assign push = dsp_grant | cpu_grant;
  assign head = mem[rd_ptr];
  assign tick = armed_q & ENABLE & (div_cnt == '0);
  assign pop  = tick & ~empty_q;

  always_comb begin
    level_n = level_q;
    if (push && !pop) begin
      level_n = level_q + 1'b1;
    end else if (!push && pop) begin
      level_n = level_q - 1'b1;
    end
  end

  // armed_q marks the first clock after reset release: the divider loads RATE
  // then, and requests are held off until that load has happened.
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values regardless of block order.
  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      armed_q <= 1'b0;
      div_cnt <= '0;
    end else if (!armed_q) begin
      armed_q <= 1'b1;
      div_cnt <= RATE;
    end else if (!ENABLE || div_cnt == '0) begin
      div_cnt <= RATE;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  // NOTE: sample storage carries no reset; stale contents are unreachable
  // once the pointers and level clear, and an unreset array maps to RAM.
  always_ff @(posedge MasterClock) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level_q <= level_n;
      full_q  <= (level_n == LW'(DEPTH));
      empty_q <= (level_n == '0);
    end
  end

  // Output stage: strobes default high and drop for one cycle after a pop.
  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      wrl_q  <= 1'b1;
      wrr_q  <= 1'b1;
      dacd_q <= '0;
    end else begin
      wrl_q <= 1'b1;
      wrr_q <= 1'b1;
      if (pop) begin
        dacd_q <= head.data;
        if (head.ch) begin
          wrr_q <= 1'b0;
        end else begin
          wrl_q <= 1'b0;
        end
      end
    end
  end

  // Sticky underrun; a same-cycle set beats CLRSTAT.
  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      underrun_q <= 1'b0;
    end else if (tick && empty_q) begin
      underrun_q <= 1'b1;
    end else if (CLRSTAT) begin
      underrun_q <= 1'b0;
    end
  end

  assign DSPACK   = dsp_grant;
  assign CPUACK   = cpu_grant;
  assign DACWRLL  = wrl_q;
  assign DACWRRL  = wrr_q;
  assign DACD     = dacd_q;
  assign FULL     = full_q;
  assign EMPTY    = empty_q;
  assign LEVEL    = level_q;
  assign UNDERRUN = underrun_q;

endmodule

// File: doc/dac_write_scheduler.md
Name: dac_write_scheduler

Overview:
Sequences all writes to the stereo PWM DAC pair. Two requesters, the DSP and the CPU host interface, submit 16-bit samples tagged left or right. The block arbitrates between them into a shared sample FIFO. It drains the FIFO at a programmable sample rate and emits the active-low DAC write strobes and data that the left and right PWM DACs latch. Sample format is unchanged: the DAC inverts bit 15 itself.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
RATEW, 10, width of sample-rate divider input

Ports:
MasterClock  in  1  system clock; all state on rising edge
RESETL  in  1  asynchronous active-low reset
ENABLE  in  1  drain enable; FIFO fills regardless
RATE  in  RATEW  drain period minus 1, in MasterClock cycles
DSPREQ  in  1  DSP write request, held until DSPACK
DSPCH  in  1  DSP channel: 0 = left, 1 = right
DSPD  in  16  DSP sample
DSPACK  out  1  DSP request accepted this cycle
CPUREQ  in  1  CPU write request, held until CPUACK
CPUCH  in  1  CPU channel
CPUD  in  16  CPU sample
CPUACK  out  1  CPU request accepted this cycle
CLRSTAT  in  1  clears UNDERRUN
DACWRLL  out  1  left DAC write strobe, active low, 1 cycle
DACWRRL  out  1  right DAC write strobe, active low, 1 cycle
DACD  out  16  DAC data bus
FULL  out  1  FIFO holds DEPTH entries
EMPTY  out  1  FIFO holds 0 entries
LEVEL  out  log2(DEPTH)+1  current entry count
UNDERRUN  out  1  sticky: a drain tick found the FIFO empty

Behaviour:
- Reset, asynchronous on RESETL low. Outputs return to: DACWRLL=1, DACWRRL=1, DACD=0, DSPACK=0, CPUACK=0, FULL=0, EMPTY=1, LEVEL=0, UNDERRUN=0. Read/write pointers clear to 0. Divider loads RATE on the first clock after release. FIFO contents are discarded. If a strobe is in progress when reset asserts, it is cut off immediately.
- Arbitration and push, once per cycle:
  - Push happens only if ~FULL, where FULL is taken from registered LEVEL.
  - DSP has fixed priority over CPU.
  - Grant goes to DSP if DSPREQ, else to CPU if CPUREQ.
  - The granted ACK is combinational and is high in the same cycle the entry {CH, D} is written.
  - The requester must drop REQ the following cycle. If REQ is still high after that, it counts as a new request.
  - When FULL, both ACKs are 0 and requests wait. A push is refused while FULL even if a pop occurs the same cycle.
- Divider:
  - When ENABLE=1: the counter decrements every cycle. At 0 it generates a tick and reloads from RATE, giving a tick period of RATE+1 cycles. RATE=0 produces a tick every cycle.
  - A change to RATE takes effect at the next reload.
  - When ENABLE=0: the counter is held at RATE and no ticks occur.
- Pop:
  - On a tick with ~EMPTY, the head entry is popped. The next cycle, DACD takes the entry data and exactly one of DACWRLL/DACWRRL goes low for one cycle, selected by CH.
  - DACD holds its value until the next pop.
  - Latency from tick to strobe is 1 cycle.
  - On a tick with EMPTY: no strobe is issued, DACD is unchanged, and UNDERRUN is set.
- Simultaneous push and pop when not FULL: both occur and LEVEL is unchanged.
- LEVEL, FULL and EMPTY are registered and reflect the state after the cycle's push and pop.
- Pointers wrap modulo DEPTH. LEVEL ranges 0..DEPTH.
- UNDERRUN is sticky. CLRSTAT clears it. If CLRSTAT and an underrun tick occur in the same cycle, set wins.
- Entries are delivered strictly in push order. There is no per-channel reordering.

Test Plan:
- Reset/idle: hold RESETL low, then release with ENABLE=0 → all outputs at reset values; strobes stay high for 100 cycles.
- Pacing: RATE=3, ENABLE=1, CPU pushes L:0x1234, R:0x8000, L:0xFFFF → strobes L, R, L exactly 4 cycles apart. DACD reads 0x1234, 0x8000, 0xFFFF, each valid in its strobe cycle.
- Arbitration: DSPREQ and CPUREQ asserted in the same cycle with DSPD=0xAAAA, CPUD=0x5555 → DSPACK in cycle 0, CPUACK in cycle 1. Output order is 0xAAAA then 0x5555.
- Full: ENABLE=0, DSP pushes DEPTH=8 entries → FULL=1, LEVEL=8. A ninth CPUREQ receives no ACK until ENABLE=1 frees a slot, and it is acked the cycle after that pop.
- Underrun: RATE=0, ENABLE=1, FIFO empty → UNDERRUN=1 after the first tick, no strobes. Pulsing CLRSTAT while empty re-sets it (set wins). With ENABLE=0, CLRSTAT → UNDERRUN=0.
- Reset mid-stream: 5 entries queued, RESETL pulsed low mid-strobe → strobe returns high asynchronously, LEVEL=0, EMPTY=1. The first post-reset push drains first.
